// File: rtl/jump_ctrl.sv
// Branch/jump resolution ahead of the PC: decodes jump fields against the
// registered ZERO/LESS flags and sequences two-word extended jumps.
module jump_ctrl #(
    parameter int PC_W   = 10,
    parameter int DIST_W = 6,
    parameter int EXT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_less,
    input  logic [2:0]        jmp_type,
    input  logic [DIST_W-1:0] jmp_dist,
    input  logic [1:0]        magic,
    input  logic [1:0]        ext_cond,
    input  logic [EXT_W-1:0]  ext_imm,
    output logic [PC_W-1:0]   pc_inc,
    output logic              taken,
    output logic              busy,
    output logic              zero_flag,
    output logic              less_flag
);

    typedef enum logic {IDLE, E_TAKE} state_t;

    state_t     state;
    logic [1:0] cond_q;

    function automatic logic signed [PC_W-1:0] sext_dist(input logic [DIST_W-1:0] d);
        return {{(PC_W-DIST_W){d[DIST_W-1]}}, d};
    endfunction

    function automatic logic signed [PC_W-1:0] sext_imm(input logic [EXT_W-1:0] d);
        return {{(PC_W-EXT_W){d[EXT_W-1]}}, d};
    endfunction

    function automatic logic cond_met(input logic [1:0] c, input logic z, input logic l);
        case (c)
            2'b00:   return 1'b1;
            2'b01:   return z;
            2'b10:   return l;
            default: return 1'b0;
        endcase
    endfunction

    assign busy = (state == E_TAKE);

    always_comb begin
        pc_inc = PC_W'(1);
        taken  = 1'b0;
        if (reset || stall) begin
            pc_inc = '0;
        end else if (state == E_TAKE) begin
            // The current word is the offset word; jmp_type is meaningless here.
            if (cond_met(cond_q, zero_flag, less_flag)) begin
                pc_inc = sext_imm(ext_imm);
                taken  = 1'b1;
            end
        end else begin
            case (jmp_type)
                3'd1: begin
                    pc_inc = sext_dist(jmp_dist);
                    taken  = 1'b1;
                end
                3'd2: if (zero_flag) begin
                    pc_inc = sext_dist(jmp_dist);
                    taken  = 1'b1;
                end
                3'd3: if (less_flag) begin
                    pc_inc = sext_dist(jmp_dist);
                    taken  = 1'b1;
                end
                3'd4: begin
                    pc_inc = {{(PC_W-3){1'b0}}, magic, 1'b1};
                    taken  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cond_q    <= 2'b00;
            zero_flag <= 1'b0;
            less_flag <= 1'b0;
        end else if (!stall) begin
            if (flag_we) begin
                zero_flag <= alu_zero;
                less_flag <= alu_less;
            end
            case (state)
                IDLE: if (jmp_type == 3'd5) begin
                    state  <= E_TAKE;
                    cond_q <= ext_cond;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
